// File: rtl/spi_slave_if.sv
// Register-bus and SPI pin bundle for spi_slave.
interface spi_slave_if;
  logic [4:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;
  logic        spi_sck;
  logic        spi_cs;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;

  modport slave (
    input  addr, we, re, wd, spi_sck, spi_cs, spi_mosi,
    output rd, irq, spi_miso, spi_miso_oe
  );

  modport master (
    output addr, we, re, wd, spi_sck, spi_cs, spi_mosi,
    input  rd, irq, spi_miso, spi_miso_oe
  );
endinterface

// File: rtl/spi_slave.sv
// SPI target, one byte at a time MSB first, all four CPOL/CPHA modes, single-byte TX/RX holding.
// Pins are acted on 3 clk after a transition; no flow control beyond the RXNE/TXE/OVR flags.
module spi_slave #(
  parameter int SCK_DIV_MIN = 8
) (
  input  logic       clk,
  input  logic       rst,
  spi_slave_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;

  logic [4:0] cr;
  logic       rxne, txe, ovr;
  logic [7:0] rx_data, tx_hold, tx_shift, rx_shift;
  logic [2:0] cnt;
  logic       sck_s1, sck_s2, sck_s3, cs_s1, cs_s2, cs_s3, mosi_s1, mosi_s2;
  logic [7:0] sck_gap;

  logic en, cpol, cpha, ie_rx, ie_txe, busy;
  assign en     = cr[0];
  assign cpol   = cr[1];
  assign cpha   = cr[2];
  assign ie_rx  = cr[3];
  assign ie_txe = cr[4];
  assign busy   = ~cs_s2;

  logic wr_cr, wr_sr, wr_txd, rd_rxd;
  assign wr_cr  = bus.we && (bus.addr == 5'h00);
  assign wr_sr  = bus.we && (bus.addr == 5'h04);
  assign wr_txd = bus.we && (bus.addr == 5'h08);
  assign rd_rxd = bus.re && (bus.addr == 5'h0C);

  logic cs_fall, sck_edge, lead, trail, sample, shift, leave, byte_done, reload, rxne_free;
  logic [7:0] rx_next;
  assign cs_fall   = cs_s3 & ~cs_s2;
  assign sck_edge  = sck_s3 ^ sck_s2;
  assign lead      = sck_edge && (sck_s3 == cpol);
  assign trail     = sck_edge && (sck_s2 == cpol);
  assign sample    = cpha ? trail : lead;
  assign shift     = cpha ? lead : trail;
  assign leave     = (state == ACTIVE) && (cs_s2 || !en);
  assign rx_next   = {rx_shift[6:0], mosi_s2};
  assign byte_done = (state == ACTIVE) && !leave && sample && (cnt == 3'd7);
  // A read of RXD in the same clk frees the slot, so a completing byte lands without overrun.
  assign rxne_free = !rxne || rd_rxd;
  assign reload    = ((state == IDLE) && cs_fall && en) ||
                     ((state == ACTIVE) && !leave &&
                      ((byte_done && cpha) || (shift && (cnt == 3'd0) && !cpha)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cr       <= '0;
      rxne     <= 1'b0;
      txe      <= 1'b1;
      ovr      <= 1'b0;
      rx_data  <= 8'h00;
      tx_hold  <= 8'hFF;
      tx_shift <= 8'hFF;
      rx_shift <= 8'h00;
      cnt      <= 3'd0;
      sck_s1   <= 1'b0; sck_s2  <= 1'b0; sck_s3 <= 1'b0;
      cs_s1    <= 1'b1; cs_s2   <= 1'b1; cs_s3  <= 1'b1;
      mosi_s1  <= 1'b0; mosi_s2 <= 1'b0;
      sck_gap  <= 8'hFF;
    end else begin
      sck_s1  <= bus.spi_sck;  sck_s2  <= sck_s1; sck_s3 <= sck_s2;
      cs_s1   <= bus.spi_cs;   cs_s2   <= cs_s1;  cs_s3  <= cs_s2;
      mosi_s1 <= bus.spi_mosi; mosi_s2 <= mosi_s1;
      if (sck_edge)              sck_gap <= 8'd1;
      else if (sck_gap != 8'hFF) sck_gap <= sck_gap + 8'd1;

      if (wr_cr)  cr      <= bus.wd[4:0];
      if (wr_txd) tx_hold <= bus.wd[7:0];

      if (wr_txd)      txe <= 1'b0;
      else if (reload) txe <= 1'b1;

      if (byte_done && rxne_free) begin
        rx_data <= rx_next;
        rxne    <= 1'b1;
      end else if (rd_rxd) begin
        rxne    <= 1'b0;
      end

      if (byte_done && !rxne_free)    ovr <= 1'b1;
      else if (wr_sr && bus.wd[2])    ovr <= 1'b0;

      if (reload) tx_shift <= txe ? 8'hFF : tx_hold;

      case (state)
        IDLE: begin
          if (cs_fall && en) begin
            state <= ACTIVE;
            cnt   <= 3'd0;
          end
        end
        ACTIVE: begin
          if (leave) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else begin
            if (sample) begin
              rx_shift <= rx_next;
              cnt      <= cnt + 3'd1;
            end
            if (shift && (cnt != 3'd0)) tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.spi_miso    = (state == ACTIVE) ? tx_shift[7] : 1'b1;
  assign bus.spi_miso_oe = (state == ACTIVE);
  assign bus.irq         = (ie_rx & (rxne | ovr)) | (ie_txe & txe);

  always_comb begin
    bus.rd = '0;
    case (bus.addr)
      5'h00:   bus.rd = {27'b0, cr};
      5'h04:   bus.rd = {28'b0, busy, ovr, txe, rxne};
      5'h08:   bus.rd = {24'b0, tx_hold};
      5'h0C:   bus.rd = {24'b0, rx_data};
      default: bus.rd = '0;
    endcase
  end

  // Detected SCK edges during a transfer must be at least half the minimum divider apart.
  sck_rate: assert property (@(posedge clk) disable iff (rst)
    ((state == ACTIVE) && sck_edge) |-> (sck_gap >= 8'(SCK_DIV_MIN / 2)));
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a table of register-bus vectors, then hand-written SPI sequences.
module tb_spi_slave;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  spi_slave_if bus ();
  spi_slave dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int oe_cycles = 0;
  always @(negedge clk) if (bus.spi_miso_oe) oe_cycles++;

  typedef struct {
    logic        we;
    logic        re;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;
  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_op(input logic w, input logic r, input logic [4:0] a,
                        input logic [31:0] d, output logic [31:0] q);
    @(negedge clk);
    bus.addr = a; bus.we = w; bus.re = r; bus.wd = d;
    #1 q = bus.rd;
    @(negedge clk);
    bus.we = 1'b0; bus.re = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus_op(1'b1, 1'b0, a, d, q);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] q;
    bus_op(1'b0, 1'b1, a, 32'h0, q);
    check(name, q, exp);
  endtask

  // Master side: n bits MSB first; returns received bits right-aligned.
  task automatic spi_bits(input logic cpol, input logic cpha, input logic [7:0] tx,
                          input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        bus.spi_mosi = tx[7-i];
        clks(H);
        rx = {rx[6:0], bus.spi_miso};
        bus.spi_sck = ~cpol;
        clks(H);
        bus.spi_sck = cpol;
      end else begin
        bus.spi_sck  = ~cpol;
        bus.spi_mosi = tx[7-i];
        clks(H);
        rx = {rx[6:0], bus.spi_miso};
        bus.spi_sck = cpol;
        clks(H);
      end
    end
  endtask

  initial begin
    logic [31:0] q;
    logic [7:0]  rxb;
    int          oe_base;

    tbl[0]  = '{1'b0, 1'b1, 5'h00, 32'h0,        32'h0,  1'b0};
    tbl[1]  = '{1'b0, 1'b1, 5'h04, 32'h0,        32'h2,  1'b0};
    tbl[2]  = '{1'b0, 1'b1, 5'h0C, 32'h0,        32'h0,  1'b0};
    tbl[3]  = '{1'b0, 1'b1, 5'h10, 32'h0,        32'h0,  1'b0};
    tbl[4]  = '{1'b0, 1'b1, 5'h1C, 32'h0,        32'h0,  1'b0};
    tbl[5]  = '{1'b1, 1'b0, 5'h00, 32'h11,       32'h0,  1'b1};
    tbl[6]  = '{1'b0, 1'b1, 5'h00, 32'h0,        32'h11, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 5'h08, 32'hA5,       32'h0,  1'b0};
    tbl[8]  = '{1'b0, 1'b1, 5'h04, 32'h0,        32'h0,  1'b0};
    tbl[9]  = '{1'b1, 1'b0, 5'h04, 32'h4,        32'h0,  1'b0};
    tbl[10] = '{1'b0, 1'b1, 5'h04, 32'h0,        32'h0,  1'b0};
    tbl[11] = '{1'b1, 1'b0, 5'h00, 32'hFFFFFFE9, 32'h0,  1'b0};
    tbl[12] = '{1'b0, 1'b1, 5'h00, 32'h0,        32'h09, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 5'h04, 32'hFFFFFFFF, 32'h0,  1'b0};
    tbl[14] = '{1'b0, 1'b1, 5'h04, 32'h0,        32'h0,  1'b0};

    bus.addr = '0; bus.we = 1'b0; bus.re = 1'b0; bus.wd = '0;
    bus.spi_cs = 1'b1; bus.spi_sck = 1'b0; bus.spi_mosi = 1'b0;
    rst = 1'b1;
    clks(3);
    check("rst_miso", {31'b0, bus.spi_miso}, 32'h1);
    check("rst_oe",   {31'b0, bus.spi_miso_oe}, 32'h0);
    check("rst_irq",  {31'b0, bus.irq}, 32'h0);
    rst = 1'b0;
    clks(2);

    for (int i = 0; i < 15; i++) begin
      bus_op(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wd, q);
      if (tbl[i].re) check($sformatf("tbl%0d_rd", i), q, tbl[i].exp_rd);
      check($sformatf("tbl%0d_irq", i), {31'b0, bus.irq}, {31'b0, tbl[i].exp_irq});
    end

    // Mode 0: TXD=0xA5 already held, CR = EN|IE_RX.
    bus.spi_cs = 1'b0;
    clks(2);
    check("m0_oe_lat2", {31'b0, bus.spi_miso_oe}, 32'h0);
    clks(1);
    check("m0_oe_lat3", {31'b0, bus.spi_miso_oe}, 32'h1);
    clks(3);
    spi_bits(1'b0, 1'b0, 8'h3C, 7, rxb);
    bus.spi_mosi = 1'b0;
    clks(H);
    rxb = {rxb[6:0], bus.spi_miso};
    bus.spi_sck = 1'b1;
    clks(2);
    check("m0_irq_lat2", {31'b0, bus.irq}, 32'h0);
    clks(1);
    check("m0_irq_lat3", {31'b0, bus.irq}, 32'h1);
    clks(H - 3);
    bus.spi_sck = 1'b0;
    clks(H);
    check("m0_master_rx", {24'b0, rxb}, 32'hA5);
    bus.spi_cs = 1'b1;
    clks(H);
    check("m0_irq", {31'b0, bus.irq}, 32'h1);
    rd_chk("m0_sr", 5'h04, 32'h3);
    rd_chk("m0_rxd", 5'h0C, 32'h3C);
    check("m0_irq_clr", {31'b0, bus.irq}, 32'h0);

    // Mode 3: two back-to-back bytes, TXD refilled once TXE rises.
    bus.spi_sck = 1'b1;
    clks(4);
    wr(5'h00, 32'h0F);
    wr(5'h08, 32'hA5);
    bus.spi_cs = 1'b0;
    clks(H);
    rd_chk("m3_sr_start", 5'h04, 32'hA);
    wr(5'h08, 32'h55);
    spi_bits(1'b1, 1'b1, 8'h81, 8, rxb);
    check("m3_master_rx0", {24'b0, rxb}, 32'hA5);
    rd_chk("m3_sr_b0", 5'h04, 32'hB);
    rd_chk("m3_rxd_b0", 5'h0C, 32'h81);
    spi_bits(1'b1, 1'b1, 8'h7E, 8, rxb);
    check("m3_master_rx1", {24'b0, rxb}, 32'h55);
    rd_chk("m3_sr_b1", 5'h04, 32'hB);
    rd_chk("m3_rxd_b1", 5'h0C, 32'h7E);
    bus.spi_cs = 1'b1;
    clks(H);

    // Overrun: three bytes without reading RXD, TX underruns to 0xFF.
    bus.spi_sck = 1'b0;
    clks(4);
    wr(5'h00, 32'h09);
    bus.spi_cs = 1'b0;
    clks(H);
    spi_bits(1'b0, 1'b0, 8'h11, 8, rxb);
    check("ovr_underrun_rx", {24'b0, rxb}, 32'hFF);
    spi_bits(1'b0, 1'b0, 8'h22, 8, rxb);
    spi_bits(1'b0, 1'b0, 8'h33, 8, rxb);
    clks(H);
    bus.spi_cs = 1'b1;
    clks(H);
    check("ovr_irq", {31'b0, bus.irq}, 32'h1);
    rd_chk("ovr_sr", 5'h04, 32'h7);
    rd_chk("ovr_rxd", 5'h0C, 32'h11);
    wr(5'h04, 32'h4);
    rd_chk("ovr_sr_clr", 5'h04, 32'h2);
    check("ovr_irq_clr", {31'b0, bus.irq}, 32'h0);

    // Abort after 5 bits, then a full byte to show the bit counter restarted.
    bus.spi_cs = 1'b0;
    clks(H);
    spi_bits(1'b0, 1'b0, 8'hF0, 5, rxb);
    check("abort_master_rx", {24'b0, rxb}, 32'h1F);
    clks(H);
    bus.spi_cs = 1'b1;
    clks(3);
    check("abort_oe", {31'b0, bus.spi_miso_oe}, 32'h0);
    rd_chk("abort_sr", 5'h04, 32'h2);
    wr(5'h08, 32'hC3);
    bus.spi_cs = 1'b0;
    clks(H);
    spi_bits(1'b0, 1'b0, 8'h5A, 8, rxb);
    check("abort_next_rx", {24'b0, rxb}, 32'hC3);
    clks(H);
    bus.spi_cs = 1'b1;
    clks(H);
    rd_chk("abort_next_sr", 5'h04, 32'h3);
    rd_chk("abort_next_rxd", 5'h0C, 32'h5A);

    // Synchronous reset mid-byte.
    wr(5'h08, 32'h3C);
    bus.spi_cs = 1'b0;
    clks(H);
    spi_bits(1'b0, 1'b0, 8'h96, 4, rxb);
    clks(2);
    rst = 1'b1;
    clks(1);
    rst = 1'b0;
    check("mrst_oe",   {31'b0, bus.spi_miso_oe}, 32'h0);
    check("mrst_miso", {31'b0, bus.spi_miso}, 32'h1);
    check("mrst_irq",  {31'b0, bus.irq}, 32'h0);
    rd_chk("mrst_cr", 5'h00, 32'h0);
    clks(2);
    rd_chk("mrst_sr", 5'h04, 32'hA);
    rd_chk("mrst_rxd", 5'h0C, 32'h0);
    bus.spi_cs = 1'b1;
    clks(H);

    // CS activity with EN=0: pins ignored, nothing changes.
    oe_base = oe_cycles;
    bus.spi_cs = 1'b0;
    clks(H);
    spi_bits(1'b0, 1'b0, 8'h99, 8, rxb);
    check("dis_master_rx", {24'b0, rxb}, 32'hFF);
    clks(H);
    bus.spi_cs = 1'b1;
    clks(H);
    check("dis_oe_cycles", oe_cycles, oe_base);
    rd_chk("dis_sr", 5'h04, 32'h2);
    rd_chk("dis_rxd", 5'h0C, 32'h0);
    check("dis_irq", {31'b0, bus.irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
